// File: rtl/lsu_stage.sv
// MEM pipeline stage: latches the EX result, runs one data-bus access per memory entry, presents the WB payload.
// Optional macro LSU_MISALIGN_CHK_EN: flags misaligned half/word accesses and skips the bus for them.
module lsu_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_ena,
    input  logic              mem_valid,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [4:0]        in_rd,
    input  logic              in_wen,
    output logic              mem_stall,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd,
    output logic              wb_wen,
    output logic [DATA_W-1:0] wb_data
`ifdef LSU_MISALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg;
    logic                stage_valid_reg;
    logic                load_reg;
    logic                store_reg;
    logic [1:0]          size_reg;
    logic                unsigned_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   alu_reg;
    logic [4:0]          rd_reg;
    logic                wen_reg;
    logic [DATA_W-1:0]   load_data_reg;
    logic                misalign_reg;

    logic [1:0]          off;
    logic [DATA_W-1:0]   rdata_sh;
    logic [DATA_W-1:0]   load_ext;
    logic [3:0]          strb_base;
    logic                in_misalign;
    logic                in_is_mem;

    assign off       = addr_reg[1:0];
    assign in_is_mem = mem_valid & (in_load | in_store);

`ifdef LSU_MISALIGN_CHK_EN
    // Size 3 is treated as a word, hence the test on in_size[1] alone.
    assign in_misalign = ((in_size == 2'd1) & in_addr[0]) |
                         (in_size[1] & (in_addr[1:0] != 2'b00));
    assign misalign_o  = misalign_reg & stage_valid_reg & (state_reg == DONE);
`else
    assign in_misalign = 1'b0;
`endif

    // Load lane extraction and sign/zero extension.
    always_comb begin
        rdata_sh = resp_rdata >> {off, 3'b000};
        load_ext = rdata_sh;
        case (size_reg)
            2'd0: load_ext = {{(DATA_W-8){~unsigned_reg & rdata_sh[7]}}, rdata_sh[7:0]};
            2'd1: load_ext = {{(DATA_W-16){~unsigned_reg & rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_ext = rdata_sh;
        endcase
    end

    always_comb begin
        case (size_reg)
            2'd0:    strb_base = 4'b0001 << off;
            2'd1:    strb_base = 4'b0011 << off;
            default: strb_base = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            stage_valid_reg <= 1'b0;
            load_reg        <= 1'b0;
            store_reg       <= 1'b0;
            size_reg        <= 2'd0;
            unsigned_reg    <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            alu_reg         <= '0;
            rd_reg          <= 5'd0;
            wen_reg         <= 1'b0;
            load_data_reg   <= '0;
            misalign_reg    <= 1'b0;
        end else if (mem_ena) begin
            stage_valid_reg <= mem_valid;
            load_reg        <= in_load;
            store_reg       <= in_store;
            size_reg        <= in_size;
            unsigned_reg    <= in_unsigned;
            addr_reg        <= in_addr;
            wdata_reg       <= in_wdata;
            alu_reg         <= in_alu;
            rd_reg          <= in_rd;
            wen_reg         <= in_wen;
            misalign_reg    <= in_is_mem & in_misalign;
            if (in_is_mem)
                state_reg <= in_misalign ? DONE : REQ;
            else
                state_reg <= IDLE;
        end else begin
            case (state_reg)
                REQ: if (req_ready) state_reg <= WAIT;
                WAIT: begin
                    if (resp_valid) begin
                        state_reg <= DONE;
                        if (load_reg) load_data_reg <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request fields come straight from the stage register, so they stay stable while REQ waits on ready.
    assign mem_stall  = (state_reg == REQ) | (state_reg == WAIT);
    assign req_valid  = (state_reg == REQ);
    assign req_we     = store_reg;
    assign req_addr   = {addr_reg[ADDR_W-1:2], 2'b00};
    assign req_wdata  = wdata_reg << {off, 3'b000};
    assign req_wstrb  = store_reg ? strb_base : 4'b0000;

    assign wb_valid_o = stage_valid_reg & ~mem_stall;
    assign wb_rd      = rd_reg;
    assign wb_wen     = wen_reg & wb_valid_o & ~store_reg & ~misalign_reg;
    assign wb_data    = load_reg ? load_data_reg : alu_reg;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: scoreboard of expected WB payloads plus bus-handshake and stall checks.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ena, mem_valid, in_load, in_store, in_unsigned, in_wen;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata, in_alu;
    logic [4:0]  in_rd;
    logic        mem_stall, req_valid, req_ready, req_we, resp_valid;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;
    logic        wb_valid_o, wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef LSU_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    lsu_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ena(mem_ena), .mem_valid(mem_valid),
        .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu), .in_rd(in_rd), .in_wen(in_wen),
        .mem_stall(mem_stall), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .wb_valid_o(wb_valid_o), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data)
`ifdef LSU_MISALIGN_CHK_EN
        , .misalign_o(misalign_o)
`endif
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_check(input string tag);
        wb_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 32'(wb_valid_o), 32'd1);
            chk({tag, "_rd"},    32'(wb_rd),      32'(e.rd));
            chk({tag, "_wen"},   32'(wb_wen),     32'(e.wen));
            chk({tag, "_data"},  wb_data,         e.data);
        end
        $display("txn %s rd=%0d wen=%0d data=%h", tag, wb_rd, wb_wen, wb_data);
    endtask

    task automatic latch(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [4:0] rd, input logic wen);
        mem_ena = 1'b1; mem_valid = v; in_load = ld; in_store = st; in_size = sz;
        in_unsigned = uns; in_addr = addr; in_wdata = wd; in_alu = alu; in_rd = rd; in_wen = wen;
        @(posedge clk); #1;
        mem_ena = 1'b0; mem_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_addr = 32'hFFFF_FFFF; in_wdata = 32'hFFFF_FFFF; in_alu = 32'hFFFF_FFFF;
    endtask

    // Serves the bus: ready in the ready_at-th REQ cycle, response in the resp_gap-th WAIT cycle.
    // resp_valid is driven high throughout REQ to show it is ignored there.
    task automatic access(input string tag, input int ready_at, input int resp_gap,
                          input logic [31:0] rdata, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        int reqc = 0;
        int waitc = 0;
        int stallc = 0;
        bit done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            stallc++;
            chk({tag, "_wbv_stall"}, 32'(wb_valid_o), 32'd0);
            if (req_valid) begin
                reqc++;
                chk({tag, "_req_we"},    32'(req_we),   32'(we));
                chk({tag, "_req_addr"},  req_addr,      addr);
                chk({tag, "_req_wdata"}, req_wdata,     wdata);
                chk({tag, "_req_wstrb"}, 32'(req_wstrb), 32'(strb));
                req_ready  = (reqc == ready_at);
                resp_valid = 1'b1;
                resp_rdata = 32'hDEAD_BEEF;
            end else begin
                waitc++;
                req_ready  = 1'b0;
                resp_valid = (waitc == resp_gap);
                resp_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        req_ready = 1'b0; resp_valid = 1'b0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s_timeout observed=stalled expected=done", tag);
        end
        chk({tag, "_req_cycles"},   32'(reqc),   32'(ready_at));
        chk({tag, "_stall_cycles"}, 32'(stallc), 32'(ready_at + resp_gap));
    endtask

    initial begin
        rst_n = 1'b0; mem_ena = 1'b0; mem_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_size = 2'd0; in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_alu = '0;
        in_rd = '0; in_wen = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        #2;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_reqv",  32'(req_valid), 32'd0);
        chk("rst_wbv",   32'(wb_valid_o), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-memory entry: no stall, result visible the cycle after the latch.
        sb_q.push_back('{rd: 5'd5, wen: 1'b1, data: 32'h0000_1234});
        latch(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        wb_check("alu");

        // Signed byte load at offset 3, ready after 3 REQ cycles, response in first WAIT cycle.
        sb_q.push_back('{rd: 5'd6, wen: 1'b1, data: 32'hFFFF_FF80});
        latch(1, 1, 0, 2'd0, 0, 32'h0000_1003, 32'h0, 32'h0, 5'd6, 1);
        access("lb", 3, 1, 32'h80FF_FF00, 1'b0, 32'h0000_1000, 32'h0, 4'b0000);
        wb_check("lb");

        // Half store at offset 2, immediate ready, ack two cycles after acceptance.
        sb_q.push_back('{rd: 5'd7, wen: 1'b0, data: 32'h0000_5555});
        latch(1, 0, 1, 2'd1, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0000_5555, 5'd7, 1);
        access("sh", 1, 2, 32'h0, 1'b1, 32'h0000_2000, 32'hABCD_0000, 4'b1100);
        wb_check("sh");

        // Signed and unsigned half loads, unsigned byte, word load.
        sb_q.push_back('{rd: 5'd8, wen: 1'b1, data: 32'hFFFF_8001});
        latch(1, 1, 0, 2'd1, 0, 32'h0000_1002, 32'h0, 32'h0, 5'd8, 1);
        access("lh", 1, 1, 32'h8001_0000, 1'b0, 32'h0000_1000, 32'h0, 4'b0000);
        wb_check("lh");
        sb_q.push_back('{rd: 5'd9, wen: 1'b1, data: 32'h0000_8001});
        latch(1, 1, 0, 2'd1, 1, 32'h0000_1002, 32'h0, 32'h0, 5'd9, 1);
        access("lhu", 2, 3, 32'h8001_0000, 1'b0, 32'h0000_1000, 32'h0, 4'b0000);
        wb_check("lhu");
        sb_q.push_back('{rd: 5'd10, wen: 1'b1, data: 32'h0000_009A});
        latch(1, 1, 0, 2'd0, 1, 32'h0000_1001, 32'h0, 32'h0, 5'd10, 1);
        access("lbu", 1, 1, 32'h0000_9A00, 1'b0, 32'h0000_1000, 32'h0, 4'b0000);
        wb_check("lbu");
        sb_q.push_back('{rd: 5'd11, wen: 1'b1, data: 32'h1234_5678});
        latch(1, 1, 0, 2'd2, 0, 32'h0000_1004, 32'h0, 32'h0, 5'd11, 1);
        access("lw", 1, 1, 32'h1234_5678, 1'b0, 32'h0000_1004, 32'h0, 4'b0000);
        wb_check("lw");
        sb_q.push_back('{rd: 5'd12, wen: 1'b0, data: 32'h0000_0001});
        latch(1, 0, 1, 2'd0, 0, 32'h0000_2001, 32'h0000_00C3, 32'h0000_0001, 5'd12, 1);
        access("sb", 1, 1, 32'h0, 1'b1, 32'h0000_2000, 32'h0000_C300, 4'b0010);
        wb_check("sb");

`ifndef LSU_MISALIGN_CHK_EN
        // Half store at offset 3: upper strobe bit and data byte fall off the top.
        sb_q.push_back('{rd: 5'd13, wen: 1'b0, data: 32'h0000_0002});
        latch(1, 0, 1, 2'd1, 0, 32'h0000_2003, 32'h0000_1234, 32'h0000_0002, 5'd13, 1);
        access("sh_trunc", 1, 1, 32'h0, 1'b1, 32'h0000_2000, 32'h3400_0000, 4'b1000);
        wb_check("sh_trunc");
`endif

        // Bubble carrying a load flag must not touch the bus.
        latch(0, 1, 0, 2'd2, 0, 32'h0000_1000, 32'h0, 32'h0, 5'd1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("bubble_reqv",  32'(req_valid),  32'd0);
            chk("bubble_stall", 32'(mem_stall),  32'd0);
            chk("bubble_wbv",   32'(wb_valid_o), 32'd0);
            @(posedge clk); #1;
        end
        $display("txn bubble reqv=%0d wbv=%0d", req_valid, wb_valid_o);

`ifdef LSU_MISALIGN_CHK_EN
        latch(1, 1, 0, 2'd2, 0, 32'h0000_3001, 32'h0, 32'h0, 5'd14, 1);
        chk("mis_reqv",  32'(req_valid),  32'd0);
        chk("mis_flag",  32'(misalign_o), 32'd1);
        chk("mis_wen",   32'(wb_wen),     32'd0);
        chk("mis_stall", 32'(mem_stall),  32'd0);
        chk("mis_wbv",   32'(wb_valid_o), 32'd1);
        $display("txn misalign misalign_o=%0d wb_wen=%0d", misalign_o, wb_wen);
        sb_q.push_back('{rd: 5'd15, wen: 1'b1, data: 32'h0000_00AA});
        latch(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0000_00AA, 5'd15, 1);
        chk("mis_clear", 32'(misalign_o), 32'd0);
        wb_check("mis_next");
`endif

        // Reset while WAIT: everything drops asynchronously, a later stray response is dropped.
        latch(1, 1, 0, 2'd2, 0, 32'h0000_1000, 32'h0, 32'h0, 5'd3, 1);
        req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        chk("rw_wait_stall", 32'(mem_stall), 32'd1);
        chk("rw_wait_reqv",  32'(req_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_stall", 32'(mem_stall),  32'd0);
        chk("rw_rst_reqv",  32'(req_valid),  32'd0);
        chk("rw_rst_wbv",   32'(wb_valid_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        resp_valid = 1'b1; resp_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(posedge clk); #1;
        chk("rw_after_stall", 32'(mem_stall),  32'd0);
        chk("rw_after_reqv",  32'(req_valid),  32'd0);
        chk("rw_after_wbv",   32'(wb_valid_o), 32'd0);
        $display("txn reset_mid_wait stall=%0d reqv=%0d wbv=%0d", mem_stall, req_valid, wb_valid_o);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- MEM pipeline stage with load/store unit: latches the EX result, performs a data-bus access, and forwards the writeback payload to WB.
- Consumes mem_ena/mem_valid from the pipeline controller and returns mem_stall to it while a bus access is outstanding.
- Bus side is a simple valid/ready request channel plus a response-valid return channel.

Parameters:
- ADDR_W, 32, address width (low 2 bits select the byte lane)
- DATA_W, 32, data width; fixed at 32, 4 byte strobes

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_ena  in  1  from controller; latch the stage register this cycle
- mem_valid  in  1  from controller; incoming entry is valid (0 = bubble)
- in_load  in  1  entry is a load
- in_store  in  1  entry is a store
- in_size  in  2  0=byte, 1=half, 2=word (3 reserved, treated as word)
- in_unsigned  in  1  zero-extend load result
- in_addr  in  ADDR_W  effective address
- in_wdata  in  32  store data, right-aligned
- in_alu  in  32  ALU result for non-memory entries
- in_rd  in  5  destination register
- in_wen  in  1  register write enable
- mem_stall  out  1  to controller; stage busy
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  ADDR_W  word-aligned address {in_addr[ADDR_W-1:2],2'b00}
- req_wdata  out  32  lane-shifted store data
- req_wstrb  out  4  byte strobes (0 for reads)
- resp_valid  in  1  response/ack valid
- resp_rdata  in  32  read data
- wb_valid_o  out  1  WB payload valid
- wb_rd  out  5  destination
- wb_wen  out  1  write enable, already qualified by wb_valid_o
- wb_data  out  32  load result or ALU result

Behaviour:
- Reset (rst_n=0, async): state=IDLE; stage_valid=0; all outputs 0.
- Stage register: on rising clk with mem_ena=1, capture all in_* fields and set stage_valid<=mem_valid. With mem_ena=0, hold.
- FSM states and transitions:
  - IDLE: no access pending.
  - REQ: req_valid=1.
  - WAIT: request accepted; awaiting response.
  - DONE: access complete; result held.
- Latch with mem_valid & (in_load|in_store) -> REQ. Any other latch -> IDLE.
- REQ: req_valid=1 and request fields held stable until req_ready=1, then -> WAIT. resp_valid is ignored in REQ.
- WAIT: on resp_valid=1 -> DONE. For a load, capture the extended resp_rdata. A store waits for resp_valid as its ack.
- DONE and IDLE: hold until the next mem_ena latch.
- resp_valid in IDLE or DONE is ignored. A stray response after reset is therefore dropped.
- mem_stall = (state==REQ) | (state==WAIT), combinational from state. The controller then holds mem_ena=0, so no latch can occur mid-access.
- Minimum memory-op latency: 2 stalled cycles (REQ accepted in cycle 1, response in cycle 2). Non-memory entries have 0 stall cycles.
- Store lanes (off=in_addr[1:0]):
  - req_wdata = in_wdata << (8*off).
  - wstrb: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - Strobe bits shifted beyond bit 3 are dropped.
- Load result:
  - r = resp_rdata >> (8*off).
  - Byte and half results are sign- or zero-extended per in_unsigned; word results are r.
- wb_valid_o = stage_valid & ~mem_stall.
- wb_wen = in_wen & wb_valid_o.
- wb_data = loaded value for loads, else in_alu. Stores force wb_wen=0.
- Reset mid-access drops req_valid immediately. The bus must tolerate request withdrawal on reset.

Optional Feature:
- Macro LSU_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign_o (1 bit).
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, skips the bus: latch -> DONE directly, with no req_valid.
  - misalign_o=stage_valid in DONE for that entry.
  - wb_wen forced 0 for that entry.
  - misalign_o is cleared on the next latch or on reset.
- Undefined: no port. Misaligned accesses are issued as-is using the truncated-strobe lane rules above.

Test Plan:
- Reset mid-WAIT: rst_n low during WAIT -> mem_stall, req_valid and wb_valid_o all 0 asynchronously. A resp_valid pulse after release is ignored and state stays IDLE.
- Non-memory entry: mem_ena=1, mem_valid=1, in_alu=0x1234, rd=5, wen=1 -> next cycle mem_stall=0, wb_valid_o=1, wb_data=0x1234, wb_wen=1.
- Signed byte load: addr=0x1003, size=0, unsigned=0; req_ready after 3 cycles; resp_rdata=0x80FF_FF00 one cycle later. Required:
  - req_valid held 3 cycles, req_addr=0x1000, req_wstrb=0.
  - mem_stall=1 for 4 cycles.
  - Then wb_data=0xFFFF_FF80.
- Half store: addr=0x2002, size=1, wdata=0xABCD; req_ready=1 immediately; resp_valid 2 cycles later. Required:
  - req_we=1, req_wdata=0xABCD_0000, req_wstrb=4'b1100.
  - wb_wen=0 once done.
- Bubble: mem_ena=1, mem_valid=0, in_load=1 -> no req_valid, wb_valid_o=0, mem_stall=0.
- LSU_MISALIGN_CHK_EN defined: word load at addr=0x3001 -> no req_valid, misalign_o=1, wb_wen=0, mem_stall=0 the cycle after the latch.
